// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-pass shift/rotate controller for the 8-bit shifter.
// Breaks shifts of up to 255 into bounded passes of at most STEP_MAX bits.
module shift_sequencer #(
    parameter int STEP_MAX = 7
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    input  logic [1:0] OPCODE,
    input  logic [7:0] OPERAND,
    input  logic [7:0] AMOUNT,
    output logic       BUSY,
    output logic       DONE,
    output logic [7:0] RESULT
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    localparam logic [3:0] STEP_LIM = 4'(STEP_MAX);

    state_t     state_q, state_d;
    logic [1:0] op_q, op_d;
    logic [7:0] w_q, w_d;
    logic [3:0] rem_q, rem_d;
    logic       done_q, done_d;
    logic [7:0] result_q, result_d;

    logic [3:0]  eff;
    logic [3:0]  step;
    logic [3:0]  rem_next;
    logic [7:0]  shifted;
    logic [15:0] rot;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= IDLE;
            op_q     <= 2'b00;
            w_q      <= 8'h00;
            rem_q    <= 4'd0;
            done_q   <= 1'b0;
            result_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            w_q      <= w_d;
            rem_q    <= rem_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    // Rotates reduce mod 8; linear shifts saturate at a full-width shift.
    always_comb begin
        eff = 4'd0;
        if (OPCODE == OP_ROR) begin
            eff = {1'b0, AMOUNT[2:0]};
        end else if (AMOUNT > 8'd8) begin
            eff = 4'd8;
        end else begin
            eff = AMOUNT[3:0];
        end
    end

    always_comb begin
        step     = (rem_q < STEP_LIM) ? rem_q : STEP_LIM;
        rem_next = rem_q - step;
        rot      = {w_q, w_q} >> step;
        shifted  = w_q;
        unique case (op_q)
            OP_SLL: shifted = w_q << step;
            OP_SRL: shifted = w_q >> step;
            OP_SRA: shifted = $signed(w_q) >>> step;
            OP_ROR: shifted = rot[7:0];
            default: shifted = w_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        w_d      = w_q;
        rem_d    = rem_q;
        done_d   = 1'b0;
        result_d = result_q;
        unique case (state_q)
            IDLE: begin
                if (START) begin
                    op_d    = OPCODE;
                    w_d     = OPERAND;
                    rem_d   = eff;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                w_d   = shifted;
                rem_d = rem_next;
                if (rem_next == 4'd0) begin
                    result_d = shifted;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        BUSY   = (state_q == SHIFT);
        DONE   = done_q;
        RESULT = result_q;
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed vectors against three STEP_MAX variants.
// Instances: index 0 STEP_MAX=7, index 1 STEP_MAX=1, index 2 STEP_MAX=2.
module tb_shift_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] start;
    logic [1:0] opcode;
    logic [7:0] operand;
    logic [7:0] amount;
    logic [2:0] busy;
    logic [2:0] done;
    logic [7:0] result [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shift_sequencer #(.STEP_MAX(7)) u_s7 (
        .CLK(clk), .RESET(reset), .START(start[0]), .OPCODE(opcode),
        .OPERAND(operand), .AMOUNT(amount), .BUSY(busy[0]),
        .DONE(done[0]), .RESULT(result[0])
    );

    shift_sequencer #(.STEP_MAX(1)) u_s1 (
        .CLK(clk), .RESET(reset), .START(start[1]), .OPCODE(opcode),
        .OPERAND(operand), .AMOUNT(amount), .BUSY(busy[1]),
        .DONE(done[1]), .RESULT(result[1])
    );

    shift_sequencer #(.STEP_MAX(2)) u_s2 (
        .CLK(clk), .RESET(reset), .START(start[2]), .OPCODE(opcode),
        .OPERAND(operand), .AMOUNT(amount), .BUSY(busy[2]),
        .DONE(done[2]), .RESULT(result[2])
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one request; returns #1 after the accepting edge.
    task automatic issue(input int d, input logic [1:0] op,
                         input logic [7:0] opd, input logic [7:0] amt);
        @(negedge clk);
        opcode   = op;
        operand  = opd;
        amount   = amt;
        start[d] = 1'b1;
        @(posedge clk);
        #1;
        start[d] = 1'b0;
    endtask

    // Counts edges until DONE, bounded, then checks the one-cycle pulse.
    task automatic wait_done(input int d, input int exp_p,
                             input logic [7:0] exp, input string tag);
        int n = 0;
        chk({tag, "_busy"}, busy[d], 1);
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!done[d] && n < 40);
        chk({tag, "_lat"}, n, exp_p);
        chk({tag, "_res"}, result[d], exp);
        chk({tag, "_busy_at_done"}, busy[d], 0);
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, done[d], 0);
    endtask

    task automatic run(input int d, input logic [1:0] op,
                       input logic [7:0] opd, input logic [7:0] amt,
                       input logic [7:0] exp, input int exp_p,
                       input string tag);
        issue(d, op, opd, amt);
        wait_done(d, exp_p, exp, tag);
    endtask

    initial begin
        int pulses;
        reset   = 1'b1;
        start   = 3'b000;
        opcode  = 2'b00;
        operand = 8'h00;
        amount  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_busy%0d", i), busy[i], 0);
            chk($sformatf("rst_done%0d", i), done[i], 0);
            chk($sformatf("rst_res%0d", i), result[i], 8'h00);
        end
        @(negedge clk);
        reset = 1'b0;

        run(0, 2'b00, 8'h81, 8'd1,   8'h02, 1, "sll1");
        run(0, 2'b01, 8'hF0, 8'd200, 8'h00, 2, "srl_sat");
        run(0, 2'b10, 8'h80, 8'd9,   8'hFF, 2, "sra_sat");
        run(0, 2'b10, 8'h90, 8'd3,   8'hF2, 1, "sra3");
        run(0, 2'b11, 8'h96, 8'd11,  8'hD2, 1, "ror11");
        run(0, 2'b11, 8'h96, 8'd16,  8'h96, 1, "ror16");
        run(0, 2'b00, 8'h01, 8'd8,   8'h00, 2, "sll8");

        run(2, 2'b00, 8'h01, 8'd7,   8'h80, 4, "sll7_s2");
        run(2, 2'b00, 8'h5A, 8'd0,   8'h5A, 1, "amt0_s2");

        // START during BUSY must be dropped, not queued.
        issue(2, 2'b11, 8'h96, 8'd11);
        opcode   = 2'b00;
        operand  = 8'hFF;
        amount   = 8'd1;
        start[2] = 1'b1;
        @(posedge clk);
        #1;
        chk("ign_busy_mid", busy[2], 1);
        start[2] = 1'b0;
        wait_done(2, 1, 8'hD2, "ign");
        chk("ign_not_queued", busy[2], 0);

        // START held across DONE: second request accepted on the DONE cycle.
        @(negedge clk);
        opcode   = 2'b00;
        operand  = 8'h81;
        amount   = 8'd1;
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("b2b_busy0", busy[0], 1);
        opcode  = 2'b01;
        operand = 8'h80;
        amount  = 8'd3;
        @(posedge clk);
        #1;
        chk("b2b_done1", done[0], 1);
        chk("b2b_res1", result[0], 8'h02);
        @(posedge clk);
        #1;
        chk("b2b_done_drop", done[0], 0);
        chk("b2b_busy2", busy[0], 1);
        start[0] = 1'b0;
        @(posedge clk);
        #1;
        chk("b2b_done2", done[0], 1);
        chk("b2b_res2", result[0], 8'h10);
        @(posedge clk);
        #1;
        chk("b2b_pulse", done[0], 0);

        // Reset mid-operation on the single-bit-per-pass variant.
        run(1, 2'b00, 8'h01, 8'd3, 8'h08, 3, "sll3_s1");
        issue(1, 2'b01, 8'hFF, 8'd8);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rmid_busy_before", busy[1], 1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rmid_busy", busy[1], 0);
        chk("rmid_done", done[1], 0);
        chk("rmid_res", result[1], 8'h00);
        @(negedge clk);
        reset  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done[1]) pulses++;
        end
        chk("rmid_no_pulse", pulses, 0);
        run(1, 2'b01, 8'h80, 8'd2, 8'h20, 2, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle shift/rotate controller that sits in front of the processor's 8-bit shift datapath. It accepts one shift request through a START/BUSY/DONE handshake and latches the operands. It then performs the operation as a sequence of bounded per-cycle passes, each no larger than the shifter's single-pass capability. This frees the ALU path from combinational shift chains and supports shift amounts up to 255.

## Interface
- STEP_MAX, default 7: maximum shift distance applied per pass; legal range 1..7.
- CLK  input  1  system clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- START  input  1  request strobe; sampled only when BUSY=0.
- OPCODE  input  2  operation: 00 logical left (sll), 01 logical right (srl), 10 arithmetic right (sra), 11 rotate right (ror).
- OPERAND  input  8  value to shift.
- AMOUNT  input  8  shift distance, unsigned 0..255.
- BUSY  output  1  high while a request is in progress.
- DONE  output  1  one-cycle pulse marking RESULT valid.
- RESULT  output  8  final shifted value; held until the next accepted request completes.

## Operation
- States: IDLE, SHIFT. DONE is a registered flag, not a state.
- Acceptance in IDLE with START=1:
  - Latch OPCODE, OPERAND into working register W, and the effective amount into counter REM; go to SHIFT; BUSY←1.
- Effective amount:
  - For sll, srl, sra: min(AMOUNT, 8).
  - For ror: AMOUNT mod 8 (AMOUNT[2:0]).
- SHIFT, each cycle:
  - step = min(REM, STEP_MAX); W ← op(W, step); REM ← REM − step.
  - Fill bits: zero for sll/srl; W[7] for sra; wrapped bits for ror.
  - If REM − step = 0: RESULT ← new W, DONE←1, BUSY←0, go to IDLE.
- Pass count p = max(1, ceil(eff/STEP_MAX)). An effective amount of 0 still takes one pass (step 0, RESULT = OPERAND).
- Results:
  - Shift by 8 yields 0x00 for sll/srl and {8{OPERAND[7]}} for sra.
  - ror with AMOUNT multiple of 8 returns OPERAND.
- START while BUSY=1 is ignored and not queued. Input changes during BUSY have no effect.
- DONE is cleared the cycle after it is set, unconditionally.

## Timing
- Reset values: BUSY=0, DONE=0, RESULT=0x00, state IDLE, REM=0, W=0x00.
- RESET has priority over every other event. Asserted mid-operation, it aborts the request: DONE never pulses for it and RESULT returns to 0x00.
- Edge E0 samples START=1 in IDLE; BUSY is high from after E0.
- Edges E1..Ep perform the passes. After Ep: DONE=1, BUSY=0, RESULT valid.
- Latency from the accepting edge to DONE high is p cycles.
- Back-to-back: a new START may be sampled at edge Ep+1, the same cycle DONE is high. DONE still drops after Ep+1, and BUSY rises.
- No combinational path from inputs to outputs.

## Test plan
- Single pass, sll, STEP_MAX=7: START with OPERAND=0x81, AMOUNT=1.
  - Required: BUSY for 1 cycle, DONE pulse 1 cycle after accept, RESULT=0x02.
- Saturation, srl, STEP_MAX=7: OPERAND=0xF0, AMOUNT=200.
  - Required: eff=8, p=2, DONE 2 cycles after accept, RESULT=0x00.
  - Repeat with sra, OPERAND=0x80, AMOUNT=9. Required: RESULT=0xFF.
- sra and ror: sra OPERAND=0x90, AMOUNT=3 → RESULT=0xF2.
  - ror OPERAND=0x96, AMOUNT=11 → eff=3, RESULT=0xD2.
  - ror AMOUNT=16 → RESULT=0x96, p=1.
- Multi-pass, STEP_MAX=2: sll OPERAND=0x01, AMOUNT=7.
  - Required: 4 passes (2,2,2,1), BUSY high 4 cycles, RESULT=0x80.
  - AMOUNT=0 → 1 pass, RESULT=OPERAND.
- Handshake discipline:
  - START with different operands while BUSY is ignored; original RESULT is returned.
  - START held high across DONE: the second request is accepted on the DONE cycle, and DONE pulses again p cycles later.
- Reset mid-operation: STEP_MAX=1, srl AMOUNT=8, RESET asserted on the 3rd SHIFT cycle.
  - Required: next cycle BUSY=0, DONE=0, RESULT=0x00, no DONE pulse.
  - A subsequent request completes normally.
